hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_perf.sv | 34 +++
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and constants for the pipeline hazard controller.
//
// Contents:
//   CNT_W  width of the multiply/divide hold counter (holds MDU_LAT-2, MDU_LAT <= 16)
//   st_t   controller state: RUN (normal issue), MDU (multiply/divide hold),
//          MWAIT (waiting for the data-memory acknowledge)
package hazard_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MDU   = 2'd1,
        MWAIT = 2'd2
    } st_t;

endpackage

// File: rtl/hazard_perf.sv
// hazard_perf -- free-running hazard statistics counters.
//
// Only instantiated when HAZ_PERF_EN is defined.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pc_h          PC hold of the current cycle
//   id_flush      IF/ID flush of the current cycle
//   stall_cycles  number of cycles with pc_h high (wraps at 2^32)
//   flush_events  number of cycles with id_flush high (wraps at 2^32)
module hazard_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_h,
    input  logic        id_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_h) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (id_flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall / flush controller for a five-stage pipeline.
//
// Resolves, in priority order while running: an outstanding data-memory
// request, a multiply/divide occupying EX, a taken branch and a load-use
// dependency. Outputs are combinational from the state and the inputs.
//
// Handshake: mem_req is raised by the memory stage and stays high until
// (and including) the cycle in which mem_ack is high; a request with
// mem_ack in the same cycle completes without a stall.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1, id_rs2           ID-stage source registers
//   id_use_rs1, id_use_rs2   corresponding source is actually read
//   ex_rd                    EX-stage destination register
//   ex_memread               EX-stage instruction is a load
//   ex_branch_taken          EX resolved a taken branch / jump
//   ex_mdu_start             EX holds a multiply/divide
//   mem_req, mem_ack         data-memory handshake
//   PC_H, ID_H, EX_H         hold PC, IF/ID, ID/EX
//   ID_FLUSH, EX_FLUSH       zero IF/ID, ID/EX on the next edge
//   dbg_st                   current controller state (observation only)
//   stall_cycles,
//   flush_events             statistics, present only with HAZ_PERF_EN
//
// Build option: define HAZ_PERF_EN to add the statistics counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MDU_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] id_rs1,
    input  logic [WIDTH-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [WIDTH-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PC_H,
    output logic             ID_H,
    output logic             EX_H,
    output logic             ID_FLUSH,
    output logic             EX_FLUSH,
    output st_t              dbg_st
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    // The entry cycle in RUN is the first hold cycle, the MDU state then
    // counts cnt = MDU_LAT-2 .. 0, giving MDU_LAT held cycles in total.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

    st_t              st;
    st_t              nxt_st;
    logic [CNT_W-1:0] cnt;
    logic             mdu_done;
    logic             mdu_go;
    logic             lu;

    assign lu = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    assign dbg_st = st;

    always_comb begin
        PC_H     = 1'b0;
        ID_H     = 1'b0;
        EX_H     = 1'b0;
        ID_FLUSH = 1'b0;
        EX_FLUSH = 1'b0;
        nxt_st   = st;
        mdu_go   = 1'b0;
        if (!rst) begin
            case (st)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        PC_H   = 1'b1;
                        ID_H   = 1'b1;
                        EX_H   = 1'b1;
                        nxt_st = MWAIT;
                    end else if (ex_mdu_start && !mdu_done) begin
                        PC_H   = 1'b1;
                        ID_H   = 1'b1;
                        EX_H   = 1'b1;
                        mdu_go = 1'b1;
                        nxt_st = MDU;
                    end else if (ex_branch_taken) begin
                        // A taken branch squashes the dependent instruction,
                        // so a concurrent load-use stall is pointless.
                        ID_FLUSH = 1'b1;
                        EX_FLUSH = 1'b1;
                    end else if (lu) begin
                        // Keep the consumer in ID and send a bubble into EX.
                        PC_H     = 1'b1;
                        ID_H     = 1'b1;
                        EX_FLUSH = 1'b1;
                    end
                end
                MDU: begin
                    // Memory activity is ignored here; the busy check in
                    // RUN picks it up once the count finishes.
                    PC_H = 1'b1;
                    ID_H = 1'b1;
                    EX_H = 1'b1;
                    if (cnt == '0) begin
                        nxt_st = RUN;
                    end
                end
                MWAIT: begin
                    if (!mem_ack) begin
                        PC_H = 1'b1;
                        ID_H = 1'b1;
                        EX_H = 1'b1;
                    end else begin
                        nxt_st = RUN;
                    end
                end
                default: begin
                    nxt_st = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= RUN;
            cnt      <= '0;
            mdu_done <= 1'b0;
        end else begin
            st <= nxt_st;
            case (st)
                RUN: begin
                    // mdu_done only shields the first RUN cycle after a
                    // completed multiply/divide from retriggering.
                    mdu_done <= 1'b0;
                    if (mdu_go) begin
                        cnt <= CNT_INIT;
                    end
                end
                MDU: begin
                    if (cnt == '0) begin
                        mdu_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    hazard_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .pc_h         (PC_H),
        .id_flush     (ID_FLUSH),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule
